// File: rtl/osc_voice_scheduler.sv
// osc_voice_scheduler
//
// Time-multiplexed front end for the oscillator down-counter stage. Per-voice counters and
// periods live in a small register file; one voice is visited per cycle in round-robin order.
// The visited voice's state is presented to the external counter stage combinationally, its
// returned next state is committed at the edge ending the visit, and each trigger toggles that
// voice's square-wave output. A registered popcount of the outputs feeds the DAC/PWM stage.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              global run enable (freezes slot pointer and voice state when low)
//   voice_en        per-voice enable mask
//   cfg_we/cfg_voice/cfg_period  period write; also phase-resets the addressed voice
//   cnt_period0/1, cnt_enable, cnt_counter   drive to the counter stage for the visited voice
//   cnt_trigger, cnt_we, cnt_next            result from the counter stage
//   slot            voice currently visited
//   voice_out       registered square-wave bits
//   mix             registered popcount of voice_out
module osc_voice_scheduler #(
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned PERIOD_BITS = 8,
  parameter int unsigned LOG2_STEP   = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [NUM_VOICES-1:0]           voice_en,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0]   cfg_voice,
  input  logic [PERIOD_BITS-1:0]          cfg_period,
  output logic [PERIOD_BITS-1:0]          cnt_period0,
  output logic [PERIOD_BITS-1:0]          cnt_period1,
  output logic                            cnt_enable,
  output logic [PERIOD_BITS-1:0]          cnt_counter,
  input  logic                            cnt_trigger,
  input  logic                            cnt_we,
  input  logic [PERIOD_BITS-1:0]          cnt_next,
  output logic [$clog2(NUM_VOICES)-1:0]   slot,
  output logic [NUM_VOICES-1:0]           voice_out,
  output logic [$clog2(NUM_VOICES):0]     mix
);

  localparam int unsigned SlotW = $clog2(NUM_VOICES);
  localparam int unsigned MixW  = SlotW + 1;

  // Counter value that makes the counter stage fire on the next visit: the trigger value
  // (period0 = 0) aligned to the step grid, which is zero for every step size.
  localparam int unsigned StepMask = ~((32'd1 << LOG2_STEP) - 32'd1);
  localparam logic [PERIOD_BITS-1:0] PhaseReset = PERIOD_BITS'(32'd0 & StepMask);

  typedef logic [PERIOD_BITS-1:0] word_t;

  logic [SlotW-1:0]      slot_q, slot_d;
  word_t                 counter_q [NUM_VOICES];
  word_t                 counter_d [NUM_VOICES];
  word_t                 period_q  [NUM_VOICES];
  word_t                 period_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0] voice_out_q, voice_out_d;
  logic [MixW-1:0]       mix_q, mix_d;

  // Counter-stage drive for the visited voice.
  always_comb begin
    cnt_period0 = '0;
    cnt_period1 = period_q[slot_q];
    cnt_enable  = en & voice_en[slot_q];
    cnt_counter = counter_q[slot_q];
  end

  always_comb begin
    slot_d      = en ? slot_q + SlotW'(1) : slot_q;
    counter_d   = counter_q;
    period_d    = period_q;
    voice_out_d = voice_out_q;

    // Stage results are only meaningful while the stage was enabled for this visit.
    if (cnt_enable) begin
      if (cnt_we) begin
        counter_d[slot_q] = cnt_next;
      end
      if (cnt_trigger) begin
        voice_out_d[slot_q] = ~voice_out_q[slot_q];
      end
    end

    // Disabled voices are held in phase so re-enabling triggers on the first visit.
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      if (!voice_en[v]) begin
        counter_d[v]   = PhaseReset;
        voice_out_d[v] = 1'b0;
      end
    end

    // Config write takes priority over a same-edge write-back to the same voice.
    if (cfg_we) begin
      period_d[cfg_voice]    = cfg_period;
      counter_d[cfg_voice]   = PhaseReset;
      voice_out_d[cfg_voice] = 1'b0;
    end

    mix_d = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      mix_d = mix_d + MixW'(voice_out_d[v]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      voice_out_q <= '0;
      mix_q       <= '0;
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        counter_q[v] <= '0;
        period_q[v]  <= '0;
      end
    end else begin
      slot_q      <= slot_d;
      voice_out_q <= voice_out_d;
      mix_q       <= mix_d;
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        counter_q[v] <= counter_d[v];
        period_q[v]  <= period_d[v];
      end
    end
  end

  assign slot      = slot_q;
  assign voice_out = voice_out_q;
  assign mix       = mix_q;

endmodule

// File: tb/tb_osc_voice_scheduler.sv
// Bench for osc_voice_scheduler: behavioural counter stage, per-voice reference model,
// directed scenarios and a randomized run.
module tb_osc_voice_scheduler;

  localparam int N  = 4;
  localparam int PB = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  voice_en;
  logic          cfg_we;
  logic [SW-1:0] cfg_voice;
  logic [PB-1:0] cfg_period;
  logic [PB-1:0] cnt_period0, cnt_period1, cnt_counter, cnt_next;
  logic          cnt_enable, cnt_trigger, cnt_we;
  logic [SW-1:0] slot;
  logic [N-1:0]  voice_out;
  logic [SW:0]   mix;

  // Garbage injected on the stage result while the stage is disabled.
  logic          junk;
  logic [PB-1:0] junk_val;

  always #5 clk = ~clk;

  osc_voice_scheduler #(
    .NUM_VOICES (N),
    .PERIOD_BITS(PB),
    .LOG2_STEP  (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .voice_en   (voice_en),
    .cfg_we     (cfg_we),
    .cfg_voice  (cfg_voice),
    .cfg_period (cfg_period),
    .cnt_period0(cnt_period0),
    .cnt_period1(cnt_period1),
    .cnt_enable (cnt_enable),
    .cnt_counter(cnt_counter),
    .cnt_trigger(cnt_trigger),
    .cnt_we     (cnt_we),
    .cnt_next   (cnt_next),
    .slot       (slot),
    .voice_out  (voice_out),
    .mix        (mix)
  );

  // Counter stage, step 1: fire on reaching period0, reload to period1-1, otherwise count down.
  always_comb begin
    cnt_trigger = 1'b0;
    cnt_we      = 1'b0;
    cnt_next    = '0;
    if (cnt_enable) begin
      cnt_we = 1'b1;
      if (cnt_counter == cnt_period0) begin
        cnt_trigger = 1'b1;
        cnt_next    = cnt_period1 - 8'd1;
      end else begin
        cnt_next = cnt_counter - 8'd1;
      end
    end else if (junk) begin
      cnt_trigger = 1'b1;
      cnt_we      = 1'b1;
      cnt_next    = junk_val;
    end
  end

  // Reference model: per-voice counter/period/output and the visited voice.
  logic [PB-1:0] m_cnt [N];
  logic [PB-1:0] m_per [N];
  logic [N-1:0]  m_vout;
  int            m_slot;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_cnt[v] = '0;
      m_per[v] = '0;
    end
    m_vout = '0;
    m_slot = 0;
  endtask

  // One clock edge: a running, enabled voice toggles every period visits.
  task automatic model_edge();
    logic [PB-1:0] ncnt [N];
    logic [N-1:0]  nv;
    for (int v = 0; v < N; v++) ncnt[v] = m_cnt[v];
    nv = m_vout;
    if (en && voice_en[m_slot]) begin
      if (m_cnt[m_slot] == 0) begin
        nv[m_slot]   = ~nv[m_slot];
        ncnt[m_slot] = m_per[m_slot] - 8'd1;
      end else begin
        ncnt[m_slot] = m_cnt[m_slot] - 8'd1;
      end
    end
    for (int v = 0; v < N; v++) begin
      if (!voice_en[v]) begin
        ncnt[v] = '0;
        nv[v]   = 1'b0;
      end
    end
    if (cfg_we) begin
      m_per[cfg_voice] = cfg_period;
      ncnt[cfg_voice]  = '0;
      nv[cfg_voice]    = 1'b0;
    end
    for (int v = 0; v < N; v++) m_cnt[v] = ncnt[v];
    m_vout = nv;
    if (en) m_slot = (m_slot + 1) % N;
  endtask

  task automatic check_outputs();
    check_eq("slot", 32'(slot), 32'(m_slot));
    check_eq("cnt_enable", 32'(cnt_enable), 32'(en & voice_en[m_slot]));
    check_eq("cnt_counter", 32'(cnt_counter), 32'(m_cnt[m_slot]));
    check_eq("cnt_period1", 32'(cnt_period1), 32'(m_per[m_slot]));
    check_eq("cnt_period0", 32'(cnt_period0), 32'd0);
    check_eq("voice_out", 32'(voice_out), 32'(m_vout));
    check_eq("mix", 32'(mix), 32'($countones(m_vout)));
  endtask

  // Starts and ends at posedge+1; outputs checked on the falling edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    junk_val = 8'($urandom);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int v, input int p);
    cfg_we     = 1'b1;
    cfg_voice  = SW'(v);
    cfg_period = PB'(p);
    cycle();
    cfg_we = 1'b0;
  endtask

  int saved_slot;
  int pre_mix;
  int visit;

  initial begin
    rst_n      = 1'b1;
    en         = 1'b0;
    voice_en   = '0;
    cfg_we     = 1'b0;
    cfg_voice  = '0;
    cfg_period = '0;
    junk       = 1'b0;
    junk_val   = '0;
    model_reset();

    // Reset state
    #1 rst_n = 1'b0;
    #3;
    check_eq("rst_slot", 32'(slot), 32'd0);
    check_eq("rst_vout", 32'(voice_out), 32'd0);
    check_eq("rst_mix", 32'(mix), 32'd0);
    check_eq("rst_counter", 32'(cnt_counter), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    junk = 1'b1;

    // Single voice, period 3: toggles every 12 cycles, counter 0,2,1 on its visits
    voice_en = 4'b0001;
    cfg_write(0, 3);
    en    = 1'b1;
    visit = 0;
    for (int k = 1; k <= 30; k++) begin
      if ((k - 1) % 4 == 0) begin
        check_eq("v0_counter", 32'(cnt_counter), 32'((3 - visit % 3) % 3));
        visit++;
      end
      cycle();
      check_eq("v0_out", 32'(voice_out[0]), 32'(((k - 1) / 12) % 2 == 0));
      check_eq("v0_mix", 32'(mix), 32'(((k - 1) / 12) % 2 == 0));
    end

    // Four voices, periods 1..4
    en       = 1'b0;
    voice_en = 4'b1111;
    for (int v = 0; v < N; v++) cfg_write(v, v + 1);
    en = 1'b1;
    repeat (64) cycle();

    // Collision: config write to voice 2 on the cycle its visit triggers
    for (int i = 0; i < N && m_slot != 1; i++) cycle();
    cfg_write(2, 3);
    check_eq("coll_setup_cnt", 32'(cnt_counter), 32'd0);
    cfg_write(2, 5);
    check_eq("coll_vout2", 32'(voice_out[2]), 32'd0);
    repeat (3) cycle();
    check_eq("coll_revisit_cnt", 32'(cnt_counter), 32'd0);
    cycle();
    check_eq("coll_retrig", 32'(voice_out[2]), 32'd1);
    repeat (3) cycle();
    check_eq("coll_reload", 32'(cnt_counter), 32'd4);

    // Freeze with a config write landing during it
    en         = 1'b0;
    saved_slot = m_slot;
    repeat (4) cycle();
    cfg_write(3, 7);
    repeat (5) cycle();
    check_eq("frz_slot", 32'(slot), 32'(saved_slot));
    check_eq("frz_cfg_vout3", 32'(voice_out[3]), 32'd0);
    en = 1'b1;
    repeat (8) cycle();

    // Disable voice 1 while high, then re-enable
    for (int i = 0; i < 64 && !(m_vout[1] && m_slot == 1); i++) cycle();
    check_eq("dis_v1_high", 32'(voice_out[1]), 32'd1);
    pre_mix  = $countones(m_vout);
    voice_en = 4'b1101;
    cycle();
    check_eq("dis_v1_low", 32'(voice_out[1]), 32'd0);
    check_eq("dis_mix_dec", 32'(mix), 32'(pre_mix - 1));
    repeat (3) cycle();
    voice_en = 4'b1111;
    for (int i = 0; i < N && m_slot != 1; i++) cycle();
    check_eq("reen_cnt", 32'(cnt_counter), 32'd0);
    cycle();
    check_eq("reen_trig", 32'(voice_out[1]), 32'd1);

    // Asynchronous reset mid-cycle
    repeat (5) cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("mrst_slot", 32'(slot), 32'd0);
    check_eq("mrst_vout", 32'(voice_out), 32'd0);
    check_eq("mrst_mix", 32'(mix), 32'd0);
    check_eq("mrst_counter", 32'(cnt_counter), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    voice_en = 4'b0001;
    cycle();
    check_eq("mrst_first_trig", 32'(voice_out), 32'd1);

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      en         = ($urandom_range(0, 7) != 0);
      voice_en   = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b1111;
      cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_voice  = SW'($urandom);
      cfg_period = ($urandom_range(0, 3) == 0) ? PB'($urandom_range(0, 2))
                                               : PB'($urandom_range(0, 9));
      cycle();
    end
    cfg_we = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
